uart_rx_frontend: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_byte_fifo.sv | 62 ++++++
 rtl/uart_rx_frontend.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, default bit timing and rx state encoding.
// Also holds the 3-input majority helper used for bit decisions.
package uart_pkg;

    localparam int UART_LEN             = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Registered FIFO with no bypass; push is accepted when full only if a pop
// happens in the same cycle, and a pop while empty is ignored.
module uart_byte_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_byte_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with majority-vote sampling, byte FIFO and line status pulses.
// Optional end-of-transfer idle pulse enabled by defining UART_RX_IDLE_TIMEOUT_EN.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_BITS    = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_idle
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int H     = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] SAMP_A = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] SAMP_B = CNT_W'(H);
    localparam logic [CNT_W-1:0] DECIDE = CNT_W'(H + 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8 || IDLE_BITS < 1) begin : g_bad_param
        $error("uart_rx_frontend: CLKS_PER_BIT must be >= 8 and IDLE_BITS >= 1");
    end

    logic                sync1;
    logic                rx_s;

    rx_state_t           state;
    rx_state_t           state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [2:0]          bit_idx;
    logic [2:0]          bit_next;
    logic [UART_LEN-1:0] shift_reg;
    logic [UART_LEN-1:0] shift_next;
    logic [1:0]          samp;
    logic [1:0]          samp_next;

    logic                vote;
    logic                decide;
    logic                slot_end;
    logic                byte_done;
    logic                stop_bad;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;
    logic                frame_err_q;
    logic                overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    // The third sample is the live rx_s on the decision cycle itself.
    assign vote     = maj3(samp[1], samp[0], rx_s);
    assign decide   = (cnt == DECIDE);
    assign slot_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            samp      <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            samp      <= samp_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        samp_next  = samp;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;

        if (state != IDLE && (cnt == SAMP_A || cnt == SAMP_B)) begin
            samp_next = {samp[0], rx_s};
        end

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                cnt_next = cnt + CNT_W'(1);
                if (decide && vote) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (slot_end) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    bit_next   = '0;
                end
            end
            DATA: begin
                cnt_next = cnt + CNT_W'(1);
                if (decide) begin
                    shift_next[bit_idx] = vote;
                end
                if (slot_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'(UART_LEN - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_next = cnt + CNT_W'(1);
                // Leave at the decision so a following start edge is not missed.
                if (decide) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    byte_done  = vote;
                    stop_bad   = !vote;
                end
            end
        endcase
    end

    uart_byte_fifo #(
        .WIDTH (UART_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_done),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .head      (rx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    assign rx_busy  = (state != IDLE);
    assign pop_fire = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= byte_done && fifo_full && !pop_fire;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              armed;
    logic              idle_line;
    logic              idle_fire;
    logic              push_ok;
    logic              rx_idle_q;

    assign idle_line = (state == IDLE) && rx_s;
    assign push_ok   = byte_done && (!fifo_full || pop_fire);
    assign idle_fire = armed && idle_line
                     && (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            armed     <= 1'b0;
            rx_idle_q <= 1'b0;
        end else begin
            if (!idle_line) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(IDLE_CYCLES)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (push_ok) begin
                armed <= 1'b1;
            end else if (idle_fire) begin
                armed <= 1'b0;
            end
            rx_idle_q <= idle_fire;
        end
    end

    assign rx_idle = rx_idle_q;
`else
    assign rx_idle = 1'b0;
`endif

endmodule
